// File: rtl/bcpu_mem_pkg.sv
// Shared definitions for the bcpu block-RAM port arbiter:
// requester-id width helper, arbiter state encoding and legal parameter ranges.
package bcpu_mem_pkg;

    // Legal range of the memory read latency, in CE cycles.
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    // Legal range of the number of requesters sharing one memory port.
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    // Arbiter state: free round-robin, or held by one owner for an atomic sequence.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Bits needed to hold a requester id (never less than 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcpu_rr_priority_select.sv
// Combinational round-robin select: one-hot grant to the first set request bit,
// searching from ptr upward and wrapping modulo NUM_REQ.
module bcpu_rr_priority_select
    import bcpu_mem_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant
);

    int  idx;
    logic found;

    // Walk the requesters starting at the pointer; the first pending one wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcpu_bram_port_arbiter.sv
// Shares one bcpu_dualport_bram port between NUM_REQ requesters with
// round-robin arbitration, locked (atomic) sequences and read-data steering.
module bcpu_bram_port_arbiter
    import bcpu_mem_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CE,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_WREN,
    input  logic [NUM_REQ-1:0]            REQ_LOCK,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WRDATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ-1:0]            RESP_VALID,
    output logic [DATA_WIDTH-1:0]         RESP_RDDATA,
    output logic                          MEM_EN,
    output logic                          MEM_WREN,
    output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
    output logic [DATA_WIDTH-1:0]         MEM_WRDATA,
    input  logic [DATA_WIDTH-1:0]         MEM_RDDATA
);

    localparam int ID_WIDTH = clog2(NUM_REQ);

    arb_state_t          state_reg, state_next;
    logic [ID_WIDTH-1:0] owner_reg, owner_next;
    logic [ID_WIDTH-1:0] ptr_reg, ptr_next;

    logic [NUM_REQ-1:0]  req_eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grant_id;
    logic                accept;

    logic [ADDR_WIDTH-1:0] addr_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] wrdata_arr [NUM_REQ];

    // Read-tracking pipeline: one {valid, id} per memory latency stage.
    logic                pipe_valid_reg [RD_LATENCY];
    logic [ID_WIDTH-1:0] pipe_id_reg    [RD_LATENCY];

    // Unpack the per-requester address and write-data slices.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]   = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wrdata_arr[gi] = REQ_WRDATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // While locked only the owner may compete; otherwise every pending requester.
    always_comb begin
        req_eligible = REQ_VALID;
        if (state_reg == ST_LOCKED) begin
            req_eligible = REQ_VALID & (NUM_REQ'(1) << owner_reg);
        end
    end

    bcpu_rr_priority_select #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_select (
        .req   (req_eligible),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // Encode the one-hot grant; defaults to requester 0 so the memory mux never floats.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_WIDTH'(i);
            end
        end
    end

    assign REQ_READY  = grant & {NUM_REQ{CE & ~RESET}};
    assign accept     = |REQ_READY;
    assign MEM_EN     = accept;
    assign MEM_WREN   = accept & REQ_WREN[grant_id];
    assign MEM_ADDR   = addr_arr[grant_id];
    assign MEM_WRDATA = wrdata_arr[grant_id];

    // Next-state: lock on an accepted LOCK access, release on the owner's first non-LOCK access.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        if (accept) begin
            ptr_next = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (REQ_LOCK[grant_id]) begin
                        state_next = ST_LOCKED;
                        owner_next = grant_id;
                    end
                end
                ST_LOCKED: begin
                    if (!REQ_LOCK[grant_id]) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Arbiter state registers; accept already includes CE so they hold when CE=0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
        end
    end

    // First tracking stage captures accepted reads and who issued them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_id_reg[0]    <= '0;
        end else if (CE) begin
            pipe_valid_reg[0] <= accept & ~REQ_WREN[grant_id];
            pipe_id_reg[0]    <= grant_id;
        end
    end

    // Remaining stages follow the memory's latency, advancing only on CE.
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    pipe_valid_reg[gi] <= 1'b0;
                    pipe_id_reg[gi]    <= '0;
                end else if (CE) begin
                    pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    pipe_id_reg[gi]    <= pipe_id_reg[gi-1];
                end
            end
        end
    endgenerate

    assign RESP_VALID  = pipe_valid_reg[RD_LATENCY-1] ?
                         (NUM_REQ'(1) << pipe_id_reg[RD_LATENCY-1]) : '0;
    assign RESP_RDDATA = MEM_RDDATA;

endmodule

// File: tb/tb_bcpu_bram_port_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// against a transaction-level model (round-robin rule, lock owner, response queue).
module tb_bcpu_bram_port_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            CE;
    logic [N-1:0]    REQ_VALID, REQ_WREN, REQ_LOCK;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_WRDATA;
    logic [N-1:0]    REQ_READY, RESP_VALID;
    logic [DW-1:0]   RESP_RDDATA;
    logic            MEM_EN, MEM_WREN;
    logic [AW-1:0]   MEM_ADDR;
    logic [DW-1:0]   MEM_WRDATA, MEM_RDDATA;

    always #5 CLK = ~CLK;

    bcpu_bram_port_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .REQ_VALID(REQ_VALID), .REQ_WREN(REQ_WREN), .REQ_LOCK(REQ_LOCK),
        .REQ_ADDR(REQ_ADDR), .REQ_WRDATA(REQ_WRDATA),
        .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_RDDATA(RESP_RDDATA),
        .MEM_EN(MEM_EN), .MEM_WREN(MEM_WREN), .MEM_ADDR(MEM_ADDR),
        .MEM_WRDATA(MEM_WRDATA), .MEM_RDDATA(MEM_RDDATA)
    );

    // Behavioural BRAM driven only by the MEM_* pins (latency LAT, output held when CE=0).
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd1, rd2;
    always @(posedge CLK) begin
        if (CE) begin
            if (MEM_EN && MEM_WREN) ram[MEM_ADDR] <= MEM_WRDATA;
            else if (MEM_EN) rd1 <= ram[MEM_ADDR];
            rd2 <= rd1;
        end
    end
    assign MEM_RDDATA = (LAT == 1) ? rd1 : rd2;

    // Requester-side stimulus state.
    logic [N-1:0]  v, w, l;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];

    // Reference model state.
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            left;
    } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            m_ptr, m_owner;
    bit            m_locked;
    int            exp_acc;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q        = {};
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 1'b0;
    endtask

    function automatic int model_grant();
        int i;
        if (RESET || !CE) return -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        REQ_VALID = v;
        REQ_WREN  = w;
        REQ_LOCK  = l;
        for (int i = 0; i < N; i++) begin
            REQ_ADDR[i*AW +: AW]   = a[i];
            REQ_WRDATA[i*DW +: DW] = d[i];
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        int            g;
        logic [N-1:0]  er, erv;
        logic [DW-1:0] ed;
        rsp_t          nq[$];
        drive();
        @(negedge CLK);
        g  = model_grant();
        er = (g >= 0) ? (N'(1) << g) : '0;
        check_eq("ready", 64'(REQ_READY), 64'(er));
        check_eq("mem_en", 64'(MEM_EN), 64'(g >= 0));
        if (g >= 0) begin
            check_eq("mem_wren", 64'(MEM_WREN), 64'(w[g]));
            check_eq("mem_addr", 64'(MEM_ADDR), 64'(a[g]));
            if (w[g]) check_eq("mem_wrdata", 64'(MEM_WRDATA), 64'(d[g]));
        end else begin
            check_eq("mem_wren", 64'(MEM_WREN), 64'd0);
        end
        erv = '0;
        ed  = '0;
        foreach (q[j]) begin
            if (q[j].left == 0) begin
                erv[q[j].id] = 1'b1;
                ed           = q[j].data;
            end
        end
        check_eq("resp_valid", 64'(RESP_VALID), 64'(erv));
        if (erv != '0) check_eq("resp_data", 64'(RESP_RDDATA), 64'(ed));

        exp_acc = g;
        if (!RESET && CE) begin
            nq = {};
            foreach (q[j]) if (q[j].left != 0) nq.push_back(q[j]);
            q = nq;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (w[g]) shadow[a[g]] = d[g];
                else      q.push_back('{g, shadow[a[g]], LAT});
                if (!m_locked && l[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end else if (m_locked && !l[g]) begin
                    m_locked = 1'b0;
                end
            end
            foreach (q[j]) q[j].left = q[j].left - 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input int addr, input logic [DW-1:0] data, input bit lk);
        v[i] = 1'b1;
        w[i] = wr;
        a[i] = AW'(addr);
        d[i] = data;
        l[i] = lk;
    endtask

    task automatic rand_req(input int i);
        bit lk;
        if (m_locked && m_owner == i) lk = ($urandom % 3 == 0);
        else                          lk = ($urandom % 10 == 0);
        set_req(i, ($urandom % 3 == 0), int'($urandom % 32), $urandom, lk);
    endtask

    task automatic idle_all();
        v = '0; w = '0; l = '0;
    endtask

    initial begin
        idle_all();
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        CE      = 1'b1;
        RESET   = 1'b1;
        exp_acc = -1;
        model_reset();
        @(posedge CLK);
        #1;
        // Reset: nothing granted, nothing returned.
        step();
        step();
        RESET = 1'b0;

        // Fill addresses 0..31 through requester 0; 0x010 gets 0xDEADBEEF.
        for (int k = 0; k < 32; k++) begin
            idle_all();
            set_req(0, 1'b1, k, (k == 16) ? 32'hDEADBEEF : $urandom, 1'b0);
            step();
        end
        idle_all();
        step();

        // Requester 1 reads 0x010; data returns LAT cycles later to requester 1 only.
        set_req(1, 1'b0, 16, '0, 1'b0);
        step();
        idle_all();
        repeat (3) step();

        // All four hold reads: accepts rotate one per cycle, responses in issue order.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, int'($urandom % 32), '0, 1'b0);
        repeat (8) begin
            step();
            if (exp_acc >= 0) set_req(exp_acc, 1'b0, int'($urandom % 32), '0, 1'b0);
        end
        idle_all();
        repeat (3) step();

        // Locked write from requester 2 keeps requester 0 out until the unlocking read.
        set_req(2, 1'b1, 5, 32'h12345678, 1'b1);
        set_req(0, 1'b0, 3, '0, 1'b0);
        step();
        v[2] = 1'b0;
        repeat (2) step();
        set_req(2, 1'b0, 5, '0, 1'b0);
        step();
        v[2] = 1'b0;
        step();
        idle_all();
        repeat (3) step();

        // CE low for 3 cycles right after a read accept delays the response by 3.
        set_req(1, 1'b0, 7, '0, 1'b0);
        set_req(3, 1'b0, 8, '0, 1'b0);
        step();
        CE = 1'b0;
        repeat (3) step();
        CE = 1'b1;
        idle_all();
        repeat (4) step();

        // Reset with two reads outstanding while locked: they never return.
        set_req(3, 1'b0, 9, '0, 1'b1);
        step();
        set_req(3, 1'b0, 10, '0, 1'b1);
        step();
        idle_all();
        set_req(0, 1'b0, 11, '0, 1'b0);
        set_req(2, 1'b0, 12, '0, 1'b0);
        RESET = 1'b1;
        model_reset();
        step();
        RESET = 1'b0;
        step();
        idle_all();
        repeat (4) step();

        // Randomized traffic with CE gaps, locks and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_acc == i) begin
                    if ($urandom % 4 == 0) begin
                        v[i] = 1'b0;
                        l[i] = 1'b0;
                    end else begin
                        rand_req(i);
                    end
                end else if (!v[i] && ($urandom % 3 == 0)) begin
                    rand_req(i);
                end
            end
            CE = ($urandom % 5 != 0);
            if (RESET) begin
                RESET = 1'b0;
            end else if ($urandom % 200 == 0) begin
                RESET = 1'b1;
                model_reset();
            end
            step();
        end
        RESET = 1'b0;
        CE    = 1'b1;
        idle_all();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcpu_bram_port_arbiter.md
Name: bcpu_bram_port_arbiter

Overview:
- Shares one port of bcpu_dualport_bram between NUM_REQ requesters, e.g. the barrel core data path, a DMA engine and a debug/program loader.
- Round-robin arbitration with optional locked sequences for atomic read-modify-write.
- Tracks outstanding reads through the memory's fixed read latency and steers returned data to the issuing requester.
- Sits between the requesters and the PORT_x_* pins of the memory.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, memory data width
ADDR_WIDTH, 12, memory address width
RD_LATENCY, 2, memory read latency in CE cycles. 1 = memory without output register; 2 = with output register.

Ports:
CLK  in  1  clock
RESET  in  1  reset, asynchronous, active-high
CE  in  1  clock enable; when 0 all state holds and no request is accepted
REQ_VALID  in  NUM_REQ  per-requester request pending
REQ_WREN  in  NUM_REQ  per-requester 1=write, 0=read
REQ_LOCK  in  NUM_REQ  per-requester: keep grant after this access
REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
REQ_WRDATA  in  NUM_REQ*DATA_WIDTH  packed write data
REQ_READY  out  NUM_REQ  one-hot accept; request i is accepted in a cycle with REQ_VALID[i]&REQ_READY[i]
RESP_VALID  out  NUM_REQ  one-hot read data valid
RESP_RDDATA  out  DATA_WIDTH  read data, shared by all requesters
MEM_EN  out  1  to memory PORT_x_EN
MEM_WREN  out  1  to memory PORT_x_WREN
MEM_ADDR  out  ADDR_WIDTH  to memory PORT_x_ADDR
MEM_WRDATA  out  DATA_WIDTH  to memory PORT_x_WRDATA
MEM_RDDATA  in  DATA_WIDTH  from memory PORT_x_RDDATA

Behaviour:
- Reset values: pointer=0, state=IDLE, owner=0, pipeline valids=0. REQ_READY=0, RESP_VALID=0, MEM_EN=0, MEM_WREN=0.
- MEM_ADDR/MEM_WRDATA are a don't-care while MEM_EN=0, but are driven from requester 0 so there is no X.
- Grant is combinational in the same cycle as the request. In IDLE it goes to the first i with REQ_VALID[i]=1, searching pointer, pointer+1, ... modulo NUM_REQ.
- REQ_READY = grant & CE & ~RESET. At most one bit is set.
- MEM_EN = |REQ_READY.
- MEM_WREN/MEM_ADDR/MEM_WRDATA are muxed from the granted requester.
- Pointer update: on an accept by requester i, pointer <= (i+1) mod NUM_REQ; otherwise it holds.
- State machine, IDLE/LOCKED:
  - IDLE -> LOCKED when the accepted request has REQ_LOCK=1; owner <= i.
  - In LOCKED only the owner may be granted. If the owner has no request, there is no grant and the state holds; the lock has no timeout.
  - LOCKED -> IDLE when the owner's accepted request has REQ_LOCK=0. That access is still performed.
  - REQ_LOCK is ignored on writes only for the lock-release decision? No: the lock rule is the same for reads and writes.
- Read tracking:
  - Shift pipeline of RD_LATENCY stages, each holding {valid, id[clog2(NUM_REQ)]}.
  - Stage 0 <= {accepted & ~WREN, granted id}; the pipeline advances only when CE=1.
  - RESP_VALID[id] = last-stage valid & CE-independent level. It is held while CE=0, matching the memory's held output.
  - RESP_RDDATA = MEM_RDDATA, passed straight through.
- Latency: a read accepted in cycle c gives RESP_VALID in cycle c+RD_LATENCY, assuming CE=1 throughout. Each CE=0 cycle adds one cycle.
- Throughput: one access per CE cycle. Back-to-back reads from different requesters return in issue order, one per cycle.
- Writes produce no response. They complete on the accepting edge.
- Simultaneous requests: only the granted requester's request is accepted. The others keep VALID high and must hold their signals stable until accepted.
- Reset asserted mid-operation: all state clears immediately, including the lock. Outstanding reads are discarded and never produce RESP_VALID.

Decomposition:
- Shared package bcpu_mem_pkg:
  - requester-id width function clog2
  - arbiter state encoding localparams ST_IDLE=0, ST_LOCKED=1
  - RD_LATENCY legal range constants
- One natural sub-module: bcpu_rr_priority_select. It is combinational: it takes the request vector and pointer and returns a one-hot grant. The top level holds all the state.

Test Plan:
- Reset, RESET=0, CE=1, RD_LATENCY=2; requester 1 reads address 0x010 holding 0xDEADBEEF, accepted in cycle c -> RESP_VALID=4'b0010 and RESP_RDDATA=0xDEADBEEF in cycle c+2; no other RESP_VALID.
- All four VALID held high with reads -> accepts occur in order 0,1,2,3,0,... one per cycle; RESP_VALID follows the same order with 2-cycle offset.
- Requester 2 issues write 0x005<=0x12345678 with LOCK=1, while requester 0 is also valid -> requester 0 is not granted until requester 2 issues read 0x005 with LOCK=0; that read returns 0x12345678; requester 0 is granted the next cycle.
- CE held low for 3 cycles right after a read accept -> RESP_VALID is delayed by exactly 3 cycles; there is no accept while CE=0.
- RESET pulsed while 2 reads are outstanding and state is LOCKED -> RESP_VALID never asserts for them; after reset the first grant goes to requester 0.
- RD_LATENCY=1 build: read accepted in cycle c -> RESP_VALID in cycle c+1.
